// File: rtl/sram_pkg.sv
// Shared definitions for the multi-port register-file SRAM.
//   state_t   : sweep FSM states (CLEAR zeroes the array, READY is normal use)
//   MAX_PORTS : widest write-port count the priority helper supports
//   slice_lo  : low bit of port k inside a flat packed bus of w-bit fields
//   win_port  : highest set bit of a per-write-port hit vector, i.e. the port
//               whose data lands in the array when several hit one address
package sram_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int MAX_PORTS = 32;

    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

    // Later ports overwrite earlier ones, so the last set bit is the winner.
    function automatic int win_port(input logic [MAX_PORTS-1:0] hit);
        int w;
        w = 0;
        for (int k = 0; k < MAX_PORTS; k++) begin
            if (hit[k]) begin
                w = k;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/sram_wr_arbiter.sv
// Combinational write-side qualification for sram_mprf_param.
//   ready        in  : array accepts writes (FSM in READY)
//   addr_wr      in  : packed write addresses, NUM_WR fields of SRAM_INDEX bits
//   we           in  : write enables, one per write port
//   data_wr      in  : packed write data, NUM_WR fields of SRAM_WIDTH bits
//   addr_rd      in  : packed read addresses, used to find bypass hits
//   wr_valid     out : port k really writes (enabled, in range, READY)
//   conflict_hit out: two or more valid ports share an address this cycle
//   byp_hit      out : read port r's address is written this cycle
//   byp_data     out : winning write data for read port r (packed)
module sram_wr_arbiter
    import sram_pkg::*;
#(
    parameter int SRAM_DEPTH = 16,
    parameter int SRAM_INDEX = 4,
    parameter int SRAM_WIDTH = 8,
    parameter int NUM_RD     = 6,
    parameter int NUM_WR     = 12
) (
    input  logic                         ready,
    input  logic [NUM_WR*SRAM_INDEX-1:0] addr_wr,
    input  logic [NUM_WR-1:0]            we,
    input  logic [NUM_WR*SRAM_WIDTH-1:0] data_wr,
    input  logic [NUM_RD*SRAM_INDEX-1:0] addr_rd,
    output logic [NUM_WR-1:0]            wr_valid,
    output logic                         conflict_hit,
    output logic [NUM_RD-1:0]            byp_hit,
    output logic [NUM_RD*SRAM_WIDTH-1:0] byp_data
);

    logic [SRAM_INDEX-1:0] wr_addr [NUM_WR];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WR; gi++) begin : g_wr
            assign wr_addr[gi]  = addr_wr[slice_lo(gi, SRAM_INDEX) +: SRAM_INDEX];
            // Out-of-range writes are dropped entirely, including from conflict checks.
            assign wr_valid[gi] = ready & we[gi] & (32'(wr_addr[gi]) < SRAM_DEPTH);
        end
    endgenerate

    // Pairwise equality compare over all valid write ports.
    always_comb begin
        conflict_hit = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (wr_valid[i] && wr_valid[j] && (wr_addr[i] == wr_addr[j])) begin
                    conflict_hit = 1'b1;
                end
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_byp
            logic [SRAM_INDEX-1:0] rd_addr;
            logic [MAX_PORTS-1:0]  hit;
            logic [SRAM_WIDTH-1:0] sel_data;

            assign rd_addr = addr_rd[slice_lo(gi, SRAM_INDEX) +: SRAM_INDEX];

            always_comb begin
                hit = '0;
                for (int k = 0; k < NUM_WR; k++) begin
                    hit[k] = wr_valid[k] && (wr_addr[k] == rd_addr);
                end
            end

            always_comb begin
                sel_data = '0;
                for (int k = 0; k < NUM_WR; k++) begin
                    if (hit[k] && (k == win_port(hit))) begin
                        sel_data = data_wr[k*SRAM_WIDTH +: SRAM_WIDTH];
                    end
                end
            end

            assign byp_hit[gi] = |hit;
            assign byp_data[slice_lo(gi, SRAM_WIDTH) +: SRAM_WIDTH] = sel_data;
        end
    endgenerate

endmodule

// File: rtl/sram_mprf_param.sv
// Parametrised multi-port register-file SRAM with zero-sweep initialisation.
//   clk            in  : clock
//   reset          in  : asynchronous active-high reset, restarts the sweep
//   init_i         in  : restart the zero sweep
//   addr_rd_i      in  : packed read addresses (NUM_RD x SRAM_INDEX)
//   addr_wr_i      in  : packed write addresses (NUM_WR x SRAM_INDEX)
//   we_i           in  : write enables (NUM_WR)
//   data_wr_i      in  : packed write data (NUM_WR x SRAM_WIDTH)
//   conflict_clr_i in  : clears the sticky conflict flag
//   data_rd_o      out : packed read data (NUM_RD x SRAM_WIDTH)
//   busy_o         out : array is being cleared
//   conflict_o     out : sticky same-address multi-write flag
module sram_mprf_param
    import sram_pkg::*;
#(
    parameter int SRAM_DEPTH   = 16,
    parameter int SRAM_INDEX   = 4,
    parameter int SRAM_WIDTH   = 8,
    parameter int NUM_RD       = 6,
    parameter int NUM_WR       = 12,
    parameter int READ_LATENCY = 0,
    parameter int BYPASS       = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         init_i,
    input  logic [NUM_RD*SRAM_INDEX-1:0] addr_rd_i,
    input  logic [NUM_WR*SRAM_INDEX-1:0] addr_wr_i,
    input  logic [NUM_WR-1:0]            we_i,
    input  logic [NUM_WR*SRAM_WIDTH-1:0] data_wr_i,
    input  logic                         conflict_clr_i,
    output logic [NUM_RD*SRAM_WIDTH-1:0] data_rd_o,
    output logic                         busy_o,
    output logic                         conflict_o
);

    localparam logic [SRAM_INDEX-1:0] CNT_LAST = SRAM_INDEX'(SRAM_DEPTH - 1);
    localparam bit BYPASS_EN = (READ_LATENCY == 1) && (BYPASS == 1);

    state_t                  state_reg;
    logic [SRAM_INDEX-1:0]   cnt_reg;
    logic                    conflict_reg;
    logic [SRAM_WIDTH-1:0]   sram [SRAM_DEPTH];

    logic [NUM_WR-1:0]            wr_valid;
    logic                         conflict_hit;
    logic [NUM_RD-1:0]            byp_hit;
    logic [NUM_RD*SRAM_WIDTH-1:0] byp_data;
    logic                         ready;

    assign ready      = (state_reg == ST_READY);
    assign busy_o     = (state_reg == ST_CLEAR);
    assign conflict_o = conflict_reg;

    sram_wr_arbiter #(
        .SRAM_DEPTH (SRAM_DEPTH),
        .SRAM_INDEX (SRAM_INDEX),
        .SRAM_WIDTH (SRAM_WIDTH),
        .NUM_RD     (NUM_RD),
        .NUM_WR     (NUM_WR)
    ) u_arb (
        .ready        (ready),
        .addr_wr      (addr_wr_i),
        .we           (we_i),
        .data_wr      (data_wr_i),
        .addr_rd      (addr_rd_i),
        .wr_valid     (wr_valid),
        .conflict_hit (conflict_hit),
        .byp_hit      (byp_hit),
        .byp_data     (byp_data)
    );

    // Sweep FSM: one entry per cycle; init_i in CLEAR restarts from entry 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_CLEAR;
            cnt_reg   <= '0;
        end else if (state_reg == ST_CLEAR) begin
            if (init_i) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                state_reg <= ST_READY;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + SRAM_INDEX'(1);
            end
        end else if (init_i) begin
            state_reg <= ST_CLEAR;
            cnt_reg   <= '0;
        end
    end

    // Array has no reset. Ports are visited in ascending order so the
    // highest-index port's assignment is the one that sticks.
    always_ff @(posedge clk) begin
        if (state_reg == ST_CLEAR) begin
            sram[cnt_reg] <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_valid[k]) begin
                    sram[addr_wr_i[k*SRAM_INDEX +: SRAM_INDEX]] <= data_wr_i[k*SRAM_WIDTH +: SRAM_WIDTH];
                end
            end
        end
    end

    // Set has priority over clear; conflict_hit is already gated by READY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_reg <= 1'b0;
        end else if (conflict_hit) begin
            conflict_reg <= 1'b1;
        end else if (conflict_clr_i) begin
            conflict_reg <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [SRAM_INDEX-1:0] rd_addr;
            logic [SRAM_WIDTH-1:0] rd_next;

            assign rd_addr = addr_rd_i[slice_lo(gi, SRAM_INDEX) +: SRAM_INDEX];

            // Zero while clearing or when the address is past the last entry.
            always_comb begin
                rd_next = '0;
                if (ready && (32'(rd_addr) < SRAM_DEPTH)) begin
                    if (BYPASS_EN && byp_hit[gi]) begin
                        rd_next = byp_data[slice_lo(gi, SRAM_WIDTH) +: SRAM_WIDTH];
                    end else begin
                        rd_next = sram[rd_addr];
                    end
                end
            end

            if (READ_LATENCY == 1) begin : g_reg
                logic [SRAM_WIDTH-1:0] rd_reg;
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        rd_reg <= '0;
                    end else begin
                        rd_reg <= rd_next;
                    end
                end
                assign data_rd_o[slice_lo(gi, SRAM_WIDTH) +: SRAM_WIDTH] = rd_reg;
            end else begin : g_comb
                assign data_rd_o[slice_lo(gi, SRAM_WIDTH) +: SRAM_WIDTH] = rd_next;
            end
        end
    endgenerate

endmodule

// File: tb/tb_sram_mprf_param.sv
// Directed bench for sram_mprf_param. Four instances share one stimulus:
//   d0  : defaults (depth 16, combinational read)
//   b1  : registered read with bypass
//   b0  : registered read without bypass
//   d12 : depth 12, combinational read (out-of-range behaviour)
module tb_sram_mprf_param;

    localparam int IW = 4;
    localparam int DW = 8;
    localparam int NR = 6;
    localparam int NW = 12;

    logic clk = 1'b0;
    logic reset;
    logic init_i;
    logic conflict_clr_i;
    logic [NR*IW-1:0] addr_rd_i;
    logic [NW*IW-1:0] addr_wr_i;
    logic [NW-1:0]    we_i;
    logic [NW*DW-1:0] data_wr_i;

    logic [NR*DW-1:0] rd_d0, rd_b1, rd_b0, rd_d12;
    logic busy_d0, busy_b1, busy_b0, busy_d12;
    logic cf_d0, cf_b1, cf_b0, cf_d12;

    int errors = 0;
    int checks = 0;
    int n0, n12;

    always #5 clk = ~clk;

    sram_mprf_param #(.READ_LATENCY(0)) u_d0 (
        .clk(clk), .reset(reset), .init_i(init_i), .addr_rd_i(addr_rd_i),
        .addr_wr_i(addr_wr_i), .we_i(we_i), .data_wr_i(data_wr_i),
        .conflict_clr_i(conflict_clr_i), .data_rd_o(rd_d0), .busy_o(busy_d0),
        .conflict_o(cf_d0));

    sram_mprf_param #(.READ_LATENCY(1), .BYPASS(1)) u_b1 (
        .clk(clk), .reset(reset), .init_i(init_i), .addr_rd_i(addr_rd_i),
        .addr_wr_i(addr_wr_i), .we_i(we_i), .data_wr_i(data_wr_i),
        .conflict_clr_i(conflict_clr_i), .data_rd_o(rd_b1), .busy_o(busy_b1),
        .conflict_o(cf_b1));

    sram_mprf_param #(.READ_LATENCY(1), .BYPASS(0)) u_b0 (
        .clk(clk), .reset(reset), .init_i(init_i), .addr_rd_i(addr_rd_i),
        .addr_wr_i(addr_wr_i), .we_i(we_i), .data_wr_i(data_wr_i),
        .conflict_clr_i(conflict_clr_i), .data_rd_o(rd_b0), .busy_o(busy_b0),
        .conflict_o(cf_b0));

    sram_mprf_param #(.SRAM_DEPTH(12), .SRAM_INDEX(4), .READ_LATENCY(0)) u_d12 (
        .clk(clk), .reset(reset), .init_i(init_i), .addr_rd_i(addr_rd_i),
        .addr_wr_i(addr_wr_i), .we_i(we_i), .data_wr_i(data_wr_i),
        .conflict_clr_i(conflict_clr_i), .data_rd_o(rd_d12), .busy_o(busy_d12),
        .conflict_o(cf_d12));

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_wr();
        we_i      = '0;
        addr_wr_i = '0;
        data_wr_i = '0;
    endtask

    task automatic set_wr(input int port, input logic [IW-1:0] a, input logic [DW-1:0] d);
        we_i[port]                = 1'b1;
        addr_wr_i[port*IW +: IW]  = a;
        data_wr_i[port*DW +: DW]  = d;
    endtask

    task automatic set_rd(input logic [IW-1:0] a);
        addr_rd_i = {NR{a}};
    endtask

    task automatic pulse_clr();
        conflict_clr_i = 1'b1;
        tick();
        conflict_clr_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        init_i = 1'b0;
        conflict_clr_i = 1'b0;
        clear_wr();
        set_rd(4'd0);
        tick();
        tick();

        // Reset state
        check_eq("rst_busy", 64'(busy_d0), 64'd1);
        check_eq("rst_conflict", 64'(cf_d0), 64'd0);
        check_eq("rst_rdreg", 64'(rd_b1), 64'd0);

        // Sweep length after release
        reset = 1'b0;
        n0 = 0;
        n12 = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (n0 == 0 && !busy_d0) n0 = i;
            if (n12 == 0 && !busy_d12) n12 = i;
        end
        check_eq("sweep_len16", 64'(n0), 64'd16);
        check_eq("sweep_len12", 64'(n12), 64'd12);

        for (int a = 0; a < 16; a++) begin
            set_rd(4'(a));
            #1;
            check_eq($sformatf("zero_rd_a%0d", a), 64'(rd_d0), 64'd0);
        end

        // Priority and conflict
        set_wr(2, 4'd3, 8'hAA);
        set_wr(9, 4'd3, 8'h55);
        set_rd(4'd3);
        #1;
        check_eq("lat0_prewrite", 64'(rd_d0[7:0]), 64'h00);
        tick();
        clear_wr();
        #1;
        check_eq("prio_rd3", 64'(rd_d0[7:0]), 64'h55);
        check_eq("conflict_set", 64'(cf_d0), 64'd1);
        tick();
        check_eq("conflict_hold", 64'(cf_d0), 64'd1);
        conflict_clr_i = 1'b1;
        set_wr(0, 4'd4, 8'h01);
        set_wr(1, 4'd4, 8'h02);
        tick();
        clear_wr();
        check_eq("set_beats_clr", 64'(cf_d0), 64'd1);
        tick();
        conflict_clr_i = 1'b0;
        check_eq("conflict_clr", 64'(cf_d0), 64'd0);
        set_wr(0, 4'd8, 8'hC8);
        set_wr(1, 4'd9, 8'hC9);
        tick();
        clear_wr();
        check_eq("no_conflict", 64'(cf_d0), 64'd0);
        set_rd(4'd4);
        #1;
        check_eq("prio_rd4", 64'(rd_d0[7:0]), 64'h02);

        // Registered read, bypass on/off
        set_wr(0, 4'd5, 8'h11);
        tick();
        clear_wr();
        set_wr(0, 4'd5, 8'h22);
        set_rd(4'd5);
        tick();
        clear_wr();
        check_eq("byp1_rd", 64'(rd_b1[7:0]), 64'h22);
        check_eq("byp0_rd", 64'(rd_b0[7:0]), 64'h11);
        set_wr(3, 4'd5, 8'h33);
        set_wr(7, 4'd5, 8'h77);
        tick();
        clear_wr();
        check_eq("byp1_prio", 64'(rd_b1[7:0]), 64'h77);
        check_eq("byp0_old", 64'(rd_b0[7:0]), 64'h22);
        tick();
        check_eq("reg_rd_p0", 64'(rd_b0[7:0]), 64'h77);
        check_eq("reg_rd_p5", 64'(rd_b0[47:40]), 64'h77);
        pulse_clr();

        // Out-of-range on the 12-entry instance
        set_wr(0, 4'd13, 8'h7F);
        set_wr(1, 4'd13, 8'h7F);
        tick();
        clear_wr();
        check_eq("oor_no_conflict", 64'(cf_d12), 64'd0);
        check_eq("inrange_conflict16", 64'(cf_d0), 64'd1);
        set_rd(4'd13);
        #1;
        check_eq("oor_rd", 64'(rd_d12), 64'd0);
        check_eq("d16_rd13", 64'(rd_d0[7:0]), 64'h7F);
        set_rd(4'd1);
        #1;
        check_eq("oor_no_alias", 64'(rd_d12[7:0]), 64'h00);
        set_rd(4'd3);
        #1;
        check_eq("oor_keep3", 64'(rd_d12[7:0]), 64'h55);
        pulse_clr();

        // Init mid-operation
        set_wr(0, 4'd7, 8'h3C);
        tick();
        clear_wr();
        set_rd(4'd7);
        #1;
        check_eq("pre_init_rd7", 64'(rd_d0[7:0]), 64'h3C);
        init_i = 1'b1;
        tick();
        init_i = 1'b0;
        check_eq("init_busy", 64'(busy_d0), 64'd1);
        set_wr(0, 4'd7, 8'h99);
        set_wr(1, 4'd7, 8'h98);
        set_rd(4'd3);
        #1;
        check_eq("clear_rd_forced0", 64'(rd_d0[7:0]), 64'h00);
        n0 = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 1) check_eq("clear_rdreg0", 64'(rd_b1[7:0]), 64'h00);
            if (!busy_d0) begin
                n0 = i;
                break;
            end
        end
        clear_wr();
        check_eq("init_sweep_len", 64'(n0), 64'd16);
        check_eq("sweep_no_conflict", 64'(cf_d0), 64'd0);
        set_rd(4'd7);
        #1;
        check_eq("init_cleared7", 64'(rd_d0[7:0]), 64'h00);

        // Reset in the middle of a sweep
        init_i = 1'b1;
        tick();
        init_i = 1'b0;
        repeat (8) tick();
        check_eq("midsweep_busy", 64'(busy_d0), 64'd1);
        reset = 1'b1;
        #1;
        check_eq("reset_busy", 64'(busy_d0), 64'd1);
        tick();
        reset = 1'b0;
        n0 = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (!busy_d0) begin
                n0 = i;
                break;
            end
        end
        check_eq("reset_sweep_len", 64'(n0), 64'd16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
